// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - IF stage: PC, single-outstanding imem fetch, fetch buffer, branch/flush redirect
// Optional IF_PERF_CNT_EN adds perf_fetch_o / perf_drop_o counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_drop_o
`endif
);
    localparam int unsigned PTR_W = $clog2(FB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FB_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      drop_addr_q, drop_addr_d;
    logic             pend_q, pend_d;
    logic [31:0]      pend_tgt_q, pend_tgt_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fb_pc_q   [FB_DEPTH];
    logic [31:0]      fb_inst_q [FB_DEPTH];

    logic        fb_empty, pop, branch_acc, redirect_br, push, pend_eff, can_issue, req_inflight;
    logic [31:0] tgt_eff;
    logic        stall_unused;

    assign stall_unused = ^stall[5:3];

    assign fb_empty     = (count_q == '0);
    assign pop          = !fb_empty && !stall[1];
    assign branch_acc   = branch_flag_i && !stall[2];
    assign redirect_br  = branch_acc && !fb_empty;
    assign req_inflight = (state_q != ST_IDLE);
    assign push         = imem_ack_i && (state_q == ST_REQ) && !flush && !redirect_br;
    // With an empty buffer the next returned word is the delay slot, even in the branch cycle itself.
    assign pend_eff     = pend_q || (branch_acc && fb_empty);
    assign tgt_eff      = (branch_acc && fb_empty) ? branch_target_i : pend_tgt_q;

    assign imem_req_o  = req_inflight;
    assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    assign stallreq_if = fb_empty;
    assign if_pc       = fb_empty ? 32'h0 : fb_pc_q[rd_ptr_q];
    assign if_inst     = fb_empty ? 32'h0 : fb_inst_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (redirect_br) begin
            // Only the head (delay slot) survives; it stays if ID did not take it this edge.
            wr_ptr_d = rd_ptr_q + PTR_W'(1);
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = '0;
            end else begin
                count_d  = CNT_W'(1);
            end
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        if (flush) begin
            fetch_pc_d = new_pc;
            pend_d     = 1'b0;
        end else if (redirect_br) begin
            fetch_pc_d = branch_target_i;
            pend_d     = 1'b0;
        end else begin
            if (branch_acc) begin
                pend_d     = 1'b1;
                pend_tgt_d = branch_target_i;
            end
            if (push) begin
                if (pend_eff) begin
                    fetch_pc_d = tgt_eff;
                    pend_d     = 1'b0;
                end else begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
        end
    end

    always_comb begin
        can_issue   = !stall[0] && (count_d < DEPTH_C);
        state_d     = state_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            ST_IDLE: if (can_issue) state_d = ST_REQ;
            ST_REQ: begin
                if (imem_ack_i) begin
                    state_d = can_issue ? ST_REQ : ST_IDLE;
                end else if (flush || redirect_br) begin
                    state_d     = ST_DROP;
                    drop_addr_d = fetch_pc_q;
                end
            end
            ST_DROP: if (imem_ack_i) state_d = can_issue ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            pend_q      <= pend_d;
            pend_tgt_q  <= pend_tgt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fb_pc_q[wr_ptr_q]   <= fetch_pc_q;
            fb_inst_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0]      perf_fetch_q, perf_drop_q;
    logic [CNT_W-1:0] cleared;
    logic             ack_drop;

    assign ack_drop = imem_ack_i && req_inflight && !push;

    always_comb begin
        cleared = '0;
        if (flush) cleared = count_q;
        else if (redirect_br) cleared = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_q + 32'(push);
            perf_drop_q  <= perf_drop_q + 32'(cleared) + 32'(ack_drop);
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_drop_o  = perf_drop_q;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed + randomized bench for if_fetch against a queue-level fetch model
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_r;
    logic [5:0]  stall_r;
    logic        br_r, fl_r, ack_r;
    logic [31:0] tgt_r, npc_r, rdata_r;
    logic        imem_req_o, stallreq_if;
    logic [31:0] imem_addr_o, if_pc, if_inst;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_o, perf_drop_o;
`endif

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(RST_PC), .FB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst_r), .stall(stall_r),
        .branch_flag_i(br_r), .branch_target_i(tgt_r),
        .flush(fl_r), .new_pc(npc_r),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(ack_r), .imem_rdata_i(rdata_r),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o)
`endif
    );

    // Model: buffered words, next fetch address, one outstanding request and whether it is doomed.
    logic [31:0] m_pc[$], m_inst[$];
    logic [31:0] m_fpc, m_raddr, m_ptgt, m_fetch, m_drop;
    bit          m_out, m_disc, m_pend;

    int          n_vec = 0, n_err = 0;
    int          lat_fixed, bus_wait;
    bit          bus_busy;
    logic [31:0] bus_addr;
    logic [31:0] pops[$], reqs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_pop(input string name, input int idx, input logic [31:0] exp);
        check(name, (idx < pops.size()) ? pops[idx] : 32'hDEAD_DEAD, exp);
    endtask

    task automatic check_req(input string name, input int idx, input logic [31:0] exp);
        check(name, (idx < reqs.size()) ? reqs[idx] : 32'hDEAD_DEAD, exp);
    endtask

    task automatic model_update();
        bit empty, pop, bacc, ok;
        if (rst_r) begin
            m_pc.delete(); m_inst.delete();
            m_fpc = RST_PC; m_out = 0; m_disc = 0; m_pend = 0; m_fetch = 0; m_drop = 0;
            return;
        end
        empty = (m_pc.size() == 0);
        pop   = !empty && !stall_r[1];
        bacc  = br_r && !stall_r[2];
        ok    = ack_r && m_out && !m_disc && !fl_r && !(bacc && !empty);
        if (ack_r && m_out && !ok) m_drop++;
        if (fl_r) begin
            m_drop += 32'(m_pc.size());
            m_pc.delete(); m_inst.delete();
            m_pend = 0; m_fpc = npc_r;
            if (m_out && !ack_r) m_disc = 1;
        end else begin
            if (bacc && !empty) begin
                m_drop += 32'(m_pc.size() - 1);
                while (m_pc.size() > 1) begin
                    void'(m_pc.pop_back()); void'(m_inst.pop_back());
                end
                m_pend = 0; m_fpc = tgt_r;
                if (m_out && !ack_r) m_disc = 1;
            end else if (bacc) begin
                m_pend = 1; m_ptgt = tgt_r;
            end
            if (pop) begin
                void'(m_pc.pop_front()); void'(m_inst.pop_front());
            end
            if (ok) begin
                m_pc.push_back(m_raddr); m_inst.push_back(mem_word(m_raddr)); m_fetch++;
                if (m_pend) begin m_fpc = m_ptgt; m_pend = 0; end
                else m_fpc = m_raddr + 32'd4;
            end
        end
        if (ack_r && m_out) begin m_out = 0; m_disc = 0; end
        if (!m_out && !stall_r[0] && m_pc.size() < DEPTH) begin
            m_out = 1; m_disc = 0; m_raddr = m_fpc;
        end
    endtask

    task automatic compare();
        check1("stallreq", stallreq_if, m_pc.size() == 0);
        check("if_pc", if_pc, (m_pc.size() == 0) ? 32'h0 : m_pc[0]);
        check("if_inst", if_inst, (m_inst.size() == 0) ? 32'h0 : m_inst[0]);
        check1("imem_req", imem_req_o, m_out);
        if (m_out) check("imem_addr", imem_addr_o, m_raddr);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch_o, m_fetch);
        check("perf_drop", perf_drop_o, m_drop);
`endif
    endtask

    task automatic bus_drive();
        if (ack_r) begin ack_r = 0; bus_busy = 0; end
        if (rst_r) begin
            bus_busy = 0; ack_r = 0;
        end else if (imem_req_o === 1'b1) begin
            if (!bus_busy) begin
                bus_busy = 1; bus_addr = imem_addr_o; reqs.push_back(imem_addr_o);
                bus_wait = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            if (bus_wait == 0) begin
                ack_r = 1; rdata_r = mem_word(bus_addr);
            end else begin
                bus_wait--;
            end
        end
    endtask

    task automatic cycle();
        bus_drive();
        if (!rst_r && stallreq_if === 1'b0 && !stall_r[1]) pops.push_back(if_pc);
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic wait_head(input string name, input logic [31:0] pc, input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            if (stallreq_if === 1'b0 && if_pc === pc) found = 1;
            else cycle();
        end
        check1(name, found, 1'b1);
    endtask

    task automatic redirect_flush(input logic [31:0] pc);
        fl_r = 1; npc_r = pc;
        cycle();
        fl_r = 0;
        pops.delete(); reqs.delete();
    endtask

    initial begin
        rst_r = 1; stall_r = '0; br_r = 0; tgt_r = '0; fl_r = 0; npc_r = '0;
        ack_r = 0; rdata_r = '0; lat_fixed = 0; bus_busy = 0; bus_wait = 0; bus_addr = '0;
        m_fpc = RST_PC; m_raddr = '0; m_ptgt = '0; m_fetch = '0; m_drop = '0;
        m_out = 0; m_disc = 0; m_pend = 0;

        repeat (2) cycle();
        check1("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, RST_PC);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_inst", if_inst, 32'h0);
        check1("rst_stallreq", stallreq_if, 1'b1);
        rst_r = 0;

        // Zero-wait stream from reset
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k >= 1) begin
                check("t1_if_pc", if_pc, 32'((k - 1) * 4));
                check1("t1_stallreq", stallreq_if, 1'b0);
            end
        end
        for (int i = 0; i < 4; i++) check_req("t1_req_addr", i, 32'(i * 4));

        // Fill buffer, then full stall, then release
        stall_r = 6'b000010;
        repeat (2) cycle();
        stall_r = 6'b000011;
        repeat (3) begin
            cycle();
            check("t2_hold_pc", if_pc, 32'h10);
            check1("t2_noreq", imem_req_o, 1'b0);
        end
        stall_r = '0;
        pops.delete();
        repeat (6) cycle();
        for (int i = 0; i < 6; i++) check_pop("t2_order", i, 32'h10 + 32'(i * 4));

        // Branch with buffer occupied: 0x14 is the delay slot, 0x18 discarded
        redirect_flush(32'h8);
        wait_head("t3_reach", 32'h10, 20);
        pops.delete();
        cycle();
        br_r = 1; tgt_r = 32'h100;
        cycle();
        br_r = 0;
        repeat (6) cycle();
        check_pop("t3_p0", 0, 32'h10);
        check_pop("t3_p1", 1, 32'h14);
        check_pop("t3_p2", 2, 32'h100);
        check_pop("t3_p3", 3, 32'h104);

        // Branch with empty buffer and slow bus: pending delay slot
        lat_fixed = 3;
        redirect_flush(32'h10);
        wait_head("t4_reach", 32'h10, 40);
        pops.delete();
        cycle();
        check1("t4_empty", stallreq_if, 1'b1);
        br_r = 1; tgt_r = 32'h200;
        cycle();
        br_r = 0;
        repeat (20) cycle();
        check_pop("t4_p0", 0, 32'h10);
        check_pop("t4_p1", 1, 32'h14);
        check_pop("t4_p2", 2, 32'h200);
        check_pop("t4_p3", 3, 32'h204);

        // Flush during an in-flight request
        begin
            bit found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                if (imem_req_o === 1'b1 && bus_busy && bus_wait > 0) found = 1;
                else cycle();
            end
            check1("t5_inflight", found, 1'b1);
        end
        redirect_flush(32'h180);
        check1("t5_empty", stallreq_if, 1'b1);
        repeat (20) cycle();
        check_req("t5_req0", 0, 32'h180);
        check_pop("t5_p0", 0, 32'h180);

        // Flush and branch together: flush wins
        lat_fixed = 0;
        repeat (3) cycle();
        br_r = 1; tgt_r = 32'h400;
        redirect_flush(32'h300);
        br_r = 0;
        repeat (10) cycle();
        check_req("t6_req0", 0, 32'h300);
        check_pop("t6_p0", 0, 32'h300);
        check_pop("t6_p1", 1, 32'h304);

        // Address wrap
        redirect_flush(32'hFFFF_FFF8);
        repeat (8) cycle();
        check_pop("wrap_p0", 0, 32'hFFFF_FFF8);
        check_pop("wrap_p1", 1, 32'hFFFF_FFFC);
        check_pop("wrap_p2", 2, 32'h0);
        check_pop("wrap_p3", 3, 32'h4);

        // Reset with a request outstanding
        lat_fixed = 3;
        redirect_flush(32'h40);
        rst_r = 1;
        cycle();
        rst_r = 0;
        check1("mrst_req", imem_req_o, 1'b0);
        check("mrst_addr", imem_addr_o, RST_PC);
        check1("mrst_stallreq", stallreq_if, 1'b1);
        repeat (10) cycle();

        lat_fixed = -1;
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                4: stall_r = 6'b000001;
                5: stall_r = 6'b000011;
                6: stall_r = 6'b000111;
                7: stall_r = 6'($urandom);
                default: stall_r = '0;
            endcase
            br_r  = ($urandom_range(0, 9) == 0);
            tgt_r = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            fl_r  = ($urandom_range(0, 39) == 0);
            npc_r = $urandom & 32'hFFFF_FFFC;
            rst_r = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst_r = 0; br_r = 0; fl_r = 0; stall_r = '0;
        repeat (5) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
